// File: rtl/eth_mac_tx_xgmii.sv
// eth_mac_tx_xgmii: 32-bit XGMII transmit framer.
// Emits start, preamble, payload, pad, FCS, terminate and IPG words, gated by i_clk_en.
module eth_mac_tx_xgmii #(
   parameter int MIN_IPG     = 12,
   parameter int MIN_PAYLOAD = 60
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_clk_en,
   input  logic [31:0] i_tx_data,
   input  logic [3:0]  i_tx_keep,
   input  logic        i_tx_last,
   input  logic        i_tx_valid,
   output logic        o_tx_ready,
   output logic [3:0]  o_xgmii_ctrl,
   output logic [31:0] o_xgmii_data
);

   localparam logic [31:0] W_IDLE = 32'h07070707;
   localparam logic [31:0] W_ERR  = 32'hFEFEFEFE;
   localparam logic [31:0] W_SOF  = 32'h555555FB;
   localparam logic [31:0] W_PRE  = 32'hD5555555;
   localparam logic [7:0]  MINP   = 8'(MIN_PAYLOAD);
   localparam logic [7:0]  MIPG   = 8'(MIN_IPG);

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_DATA, S_TAIL, S_IPG
   } state_t;

   state_t      state_q;
   logic [31:0] crc_q;
   logic [7:0]  cnt_q;
   logic [7:0]  pad_q;
   logic [7:0]  tpos_q;
   logic [7:0]  ipg_q;
   logic [3:0]  ctrl_q;
   logic [31:0] data_q;

   logic        in_data;
   logic [2:0]  nbytes;
   logic [7:0]  tot;
   logic [7:0]  pad_d;
   logic [7:0]  pad_w;
   logic [7:0]  t;
   logic [7:0]  ipg_d;
   logic [31:0] crc_d;
   logic [31:0] fcs;
   logic [1:0]  fidx;
   logic [31:0] wd;
   logic [3:0]  wc;
   logic        term;
   logic [7:0]  term_idles;

   // reflected CRC-32 over one byte, poly 04C11DB7
   function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int n = 0; n < 8; n++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   assign o_tx_ready   = (state_q == S_DATA) && i_clk_en;
   assign o_xgmii_ctrl = ctrl_q;
   assign o_xgmii_data = data_q;
   assign ipg_d        = ipg_q + 8'd4;

   // Lane builder: payload lanes, then tail stream (pad, FCS, /T/, idle).
   // Tail index t counts bytes after the last payload byte; CRC chains lane by lane.
   always_comb begin
      in_data = (state_q == S_DATA);
      nbytes  = 3'd4;
      if (i_tx_last) begin
         if (i_tx_keep[3])      nbytes = 3'd4;
         else if (i_tx_keep[2]) nbytes = 3'd3;
         else if (i_tx_keep[1]) nbytes = 3'd2;
         else                   nbytes = 3'd1;
      end
      tot        = cnt_q + 8'(nbytes);
      pad_d      = (tot >= MINP) ? 8'd0 : MINP - tot;
      pad_w      = in_data ? pad_d : pad_q;
      crc_d      = crc_q;
      wd         = W_IDLE;
      wc         = 4'hF;
      term       = 1'b0;
      term_idles = 8'd0;
      t          = 8'd0;
      fcs        = 32'd0;
      fidx       = 2'd0;
      for (int i = 0; i < 4; i++) begin
         t    = in_data ? 8'(i) - 8'(nbytes) : tpos_q + 8'(i);
         fcs  = ~crc_d;
         fidx = 2'(t - pad_w);
         if (in_data && (3'(i) < nbytes)) begin
            wd[8*i +: 8] = i_tx_data[8*i +: 8];
            wc[i]        = 1'b0;
            crc_d        = crc8(crc_d, i_tx_data[8*i +: 8]);
         end else if (t < pad_w) begin
            wd[8*i +: 8] = 8'h00;
            wc[i]        = 1'b0;
            crc_d        = crc8(crc_d, 8'h00);
         end else if (t < pad_w + 8'd4) begin
            wd[8*i +: 8] = fcs[8*fidx +: 8];
            wc[i]        = 1'b0;
         end else if (t == pad_w + 8'd4) begin
            wd[8*i +: 8] = 8'hFD;
            wc[i]        = 1'b1;
            term         = 1'b1;
            term_idles   = 8'(4 - i);
         end
      end
   end

   // Frame sequencer: one XGMII word per enabled cycle, held otherwise.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         ctrl_q  <= 4'hF;
         data_q  <= W_IDLE;
         crc_q   <= '1;
         cnt_q   <= '0;
         pad_q   <= '0;
         tpos_q  <= '0;
         ipg_q   <= MIPG;
      end else if (i_clk_en) begin
         unique case (state_q)
            S_IDLE: begin
               ctrl_q <= 4'hF;
               data_q <= W_IDLE;
               if (i_tx_valid && (ipg_q >= MIPG)) begin
                  ctrl_q  <= 4'h1;
                  data_q  <= W_SOF;
                  crc_q   <= '1;
                  cnt_q   <= '0;
                  state_q <= S_PRE;
               end
            end
            S_PRE: begin
               ctrl_q  <= 4'h0;
               data_q  <= W_PRE;
               state_q <= S_DATA;
            end
            S_DATA: begin
               if (i_tx_valid) begin
                  ctrl_q <= wc;
                  data_q <= wd;
                  crc_q  <= crc_d;
                  cnt_q  <= (cnt_q >= MINP) ? cnt_q : tot;
                  if (i_tx_last) begin
                     pad_q   <= pad_d;
                     tpos_q  <= 8'(3'd4 - nbytes);
                     state_q <= S_TAIL;
                  end
               end else begin
                  ctrl_q <= 4'hF;
                  data_q <= W_ERR;
               end
            end
            S_TAIL: begin
               ctrl_q <= wc;
               data_q <= wd;
               crc_q  <= crc_d;
               tpos_q <= tpos_q + 8'd4;
               if (term) begin
                  ipg_q   <= term_idles;
                  state_q <= (term_idles >= MIPG) ? S_IDLE : S_IPG;
               end
            end
            S_IPG: begin
               ctrl_q <= 4'hF;
               data_q <= W_IDLE;
               ipg_q  <= ipg_d;
               if (ipg_d >= MIPG) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
